// File: rtl/uart_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_host
// Description : Host-side command initiator for the UART register/ALU command
//               protocol. Accepts one command, sends its frame bytes on a
//               byte-level TX handshake, then collects the response bytes from
//               a byte-level RX stream, with an inter-byte response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_host #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_type_i,
    input  logic [RF_ADDR-1:0]    cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [DATA_WIDTH-1:0] cmd_opa_i,
    input  logic [DATA_WIDTH-1:0] cmd_opb_i,
    input  logic [3:0]            cmd_fun_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic [15:0]           rsp_data_o,
    output logic                  rsp_valid_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o
);

    localparam logic [1:0] C_RF_WR   = 2'd0;
    localparam logic [1:0] C_RF_RD   = 2'd1;
    localparam logic [1:0] C_ALU_OP  = 2'd2;
    localparam logic [1:0] C_ALU_NOP = 2'd3;

    localparam logic [DATA_WIDTH-1:0] C_HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] C_HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] C_HDR_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] C_HDR_NOP = DATA_WIDTH'(8'hDD);

    localparam logic [TIMEOUT_W-1:0] C_TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              type_q;
    logic [RF_ADDR-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, opa_q, opb_q;
    logic [3:0]              fun_q;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic                    rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_b0_q, rx_b0_d;
    logic [TIMEOUT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [15:0]             rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic                    w_accept;
    logic [1:0]              w_last_idx;
    logic                    w_rx_last;
    logic [DATA_WIDTH-1:0]   w_tx_byte;

    assign w_accept = (state_q == ST_IDLE) && cmd_valid_i;

    // Frame length (as last byte index) and response length per command type
    assign w_last_idx = (type_q == C_RF_WR)  ? 2'd2 :
                        (type_q == C_ALU_OP) ? 2'd3 : 2'd1;
    assign w_rx_last  = (type_q != C_RF_RD);

    // Select the frame byte at the current position from the captured command
    always_comb begin
        w_tx_byte = '0;
        case (type_q)
            C_RF_WR: begin
                case (byte_cnt_q)
                    2'd0:    w_tx_byte = C_HDR_WR;
                    2'd1:    w_tx_byte = DATA_WIDTH'(addr_q);
                    default: w_tx_byte = wdata_q;
                endcase
            end
            C_RF_RD: begin
                w_tx_byte = (byte_cnt_q == 2'd0) ? C_HDR_RD : DATA_WIDTH'(addr_q);
            end
            C_ALU_OP: begin
                case (byte_cnt_q)
                    2'd0:    w_tx_byte = C_HDR_OP;
                    2'd1:    w_tx_byte = opa_q;
                    2'd2:    w_tx_byte = opb_q;
                    default: w_tx_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                w_tx_byte = (byte_cnt_q == 2'd0) ? C_HDR_NOP : DATA_WIDTH'(fun_q);
            end
        endcase
    end

    // Capture all command fields at acceptance so CMD_* may change while busy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_q  <= C_RF_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
        end else if (w_accept) begin
            type_q  <= cmd_type_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            opa_q   <= cmd_opa_i;
            opb_q   <= cmd_opb_i;
            fun_q   <= cmd_fun_i;
        end
    end

    // State, counters and registered response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            rx_cnt_q      <= 1'b0;
            rx_b0_q       <= '0;
            tmo_cnt_q     <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_b0_q       <= rx_b0_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic: send frame, gather response, enforce inter-byte timeout
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        rx_cnt_d      = rx_cnt_q;
        rx_b0_d       = rx_b0_q;
        tmo_cnt_d     = tmo_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                rx_cnt_d   = 1'b0;
                tmo_cnt_d  = '0;
                if (cmd_valid_i) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    if (byte_cnt_q == w_last_idx) begin
                        if (type_q == C_RF_WR) begin
                            state_d     = ST_IDLE;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = 16'h0000;
                        end else begin
                            state_d   = ST_WAIT_RSP;
                            tmo_cnt_d = '0;
                            rx_cnt_d  = 1'b0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                if (rx_valid_i) begin
                    tmo_cnt_d = '0;
                    if (rx_cnt_q == w_rx_last) begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = (type_q == C_RF_RD) ? 16'(rx_data_i)
                                                          : 16'({rx_data_i, rx_b0_q});
                    end else begin
                        rx_b0_d  = rx_data_i;
                        rx_cnt_d = 1'b1;
                    end
                end else if (tmo_cnt_q == C_TMO_LAST) begin
                    state_d       = ST_IDLE;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign tx_valid_o    = (state_q == ST_SEND);
    assign tx_data_o     = (state_q == ST_SEND) ? w_tx_byte : '0;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule
`default_nettype wire
